// File: rtl/psg_write_sequencer.sv
// Buffers register bytes from an upstream valid/ready source and writes them to a
// PSG-style sound chip with CE_N/WE_N strobes, READY handshake, write gap and READY timeout.
`default_nettype none

module psg_write_sequencer #(
  parameter int FIFO_DEPTH     = 4,
  parameter int GAP_CYCLES     = 2,
  parameter int TIMEOUT_CYCLES = 200
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       in_valid,
  input  logic [7:0] in_data,
  output logic       in_ready,
  output logic       CE_N,
  output logic       WE_N,
  output logic [7:0] D_IN,
  input  logic       READY,
  output logic [3:0] fifo_count,
  output logic       busy,
  output logic       timeout_error,
  input  logic       clear_error,
  output logic [1:0] o_state
);

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_STROBE    = 2'd1,
    S_WAIT_HIGH = 2'd2,
    S_GAP       = 2'd3
  } state_t;

  localparam int         PW       = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [3:0] DEPTH_L  = 4'(FIFO_DEPTH);
  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYCLES - 1);
  localparam logic [3:0] GAP_LAST = 4'(GAP_CYCLES - 1);

  // Upstream handshake: a byte moves when in_valid and in_ready are both high on a
  // rising clock edge. in_ready depends only on registered state, never on in_valid.

  logic [7:0]    r_mem [FIFO_DEPTH];
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [3:0]    r_count;
  logic          r_rdy_en;

  state_t        r_state;
  logic          r_ce_n;
  logic          r_we_n;
  logic [7:0]    r_d_in;
  logic [7:0]    r_tmo_cnt;
  logic [3:0]    r_gap_cnt;
  logic          r_timeout_error;

  state_t        w_state_next;
  logic          w_ce_n_next;
  logic [7:0]    w_d_in_next;
  logic [7:0]    w_tmo_cnt_next;
  logic [3:0]    w_gap_cnt_next;
  logic          w_pop;
  logic          w_tmo_set;
  logic          w_push;
  logic [7:0]    w_head;

  assign w_push = in_valid && in_ready;
  assign w_head = r_mem[r_rd_ptr];

  // r_rdy_en keeps in_ready low through reset and lets it rise on the first edge after.
  assign in_ready      = r_rdy_en && (r_count < DEPTH_L);
  assign fifo_count    = r_count;
  assign busy          = (r_count != 4'd0) || (r_state != S_IDLE);
  assign CE_N          = r_ce_n;
  assign WE_N          = r_we_n;
  assign D_IN          = r_d_in;
  assign timeout_error = r_timeout_error;
  assign o_state       = r_state;

  always_ff @(posedge clock) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= in_data;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= 4'd0;
      r_rdy_en <= 1'b0;
    end else begin
      r_rdy_en <= 1'b1;
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 4'd1;
        2'b01:   r_count <= r_count - 4'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state         <= S_IDLE;
      r_ce_n          <= 1'b1;
      r_we_n          <= 1'b1;
      r_d_in          <= 8'hFF;
      r_tmo_cnt       <= 8'd0;
      r_gap_cnt       <= 4'd0;
      r_timeout_error <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_ce_n    <= w_ce_n_next;
      r_we_n    <= w_ce_n_next;
      r_d_in    <= w_d_in_next;
      r_tmo_cnt <= w_tmo_cnt_next;
      r_gap_cnt <= w_gap_cnt_next;
      // A timeout on the same edge as clear_error leaves the flag set.
      if (w_tmo_set) begin
        r_timeout_error <= 1'b1;
      end else if (clear_error) begin
        r_timeout_error <= 1'b0;
      end
    end
  end

  always_comb begin
    w_state_next   = r_state;
    w_ce_n_next    = r_ce_n;
    w_d_in_next    = r_d_in;
    w_tmo_cnt_next = r_tmo_cnt;
    w_gap_cnt_next = r_gap_cnt;
    w_pop          = 1'b0;
    w_tmo_set      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (r_count != 4'd0) begin
          w_pop          = 1'b1;
          w_d_in_next    = w_head;
          w_ce_n_next    = 1'b0;
          w_tmo_cnt_next = 8'd0;
          w_state_next   = S_STROBE;
        end
      end
      S_STROBE: begin
        if (!READY) begin
          w_state_next = S_WAIT_HIGH;
        end else if (r_tmo_cnt == TMO_LAST) begin
          w_tmo_set      = 1'b1;
          w_ce_n_next    = 1'b1;
          w_gap_cnt_next = 4'd0;
          w_state_next   = S_GAP;
        end else begin
          w_tmo_cnt_next = r_tmo_cnt + 8'd1;
        end
      end
      S_WAIT_HIGH: begin
        if (READY) begin
          w_ce_n_next    = 1'b1;
          w_gap_cnt_next = 4'd0;
          w_state_next   = S_GAP;
        end else if (r_tmo_cnt == TMO_LAST) begin
          w_tmo_set      = 1'b1;
          w_ce_n_next    = 1'b1;
          w_gap_cnt_next = 4'd0;
          w_state_next   = S_GAP;
        end else begin
          w_tmo_cnt_next = r_tmo_cnt + 8'd1;
        end
      end
      S_GAP: begin
        if (r_gap_cnt == GAP_LAST) begin
          w_state_next = S_IDLE;
        end else begin
          w_gap_cnt_next = r_gap_cnt + 4'd1;
        end
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

endmodule

`default_nettype wire

// File: tb/tb_psg_write_sequencer.sv
// Bench for psg_write_sequencer: a READY chip model, an order scoreboard fed at
// acceptance and drained on each CE_N falling edge, and directed plus random writes.
`timescale 1ns/1ps

module tb_psg_write_sequencer;

  localparam int         DEPTH       = 4;
  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_STROBE   = 2'd1;
  localparam logic [1:0] ST_WAIT     = 2'd2;
  localparam logic [1:0] ST_GAP      = 2'd3;
  localparam int         RM_NORMAL   = 0;
  localparam int         RM_HIGH     = 1;
  localparam int         RM_STUCK    = 2;

  logic       clock;
  logic       reset;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready;
  logic       CE_N;
  logic       WE_N;
  logic [7:0] D_IN;
  logic       READY;
  logic [3:0] fifo_count;
  logic       busy;
  logic       timeout_error;
  logic       clear_error;
  logic [1:0] o_state;

  int vectors;
  int miscompares;
  int pulses;
  int ready_mode;
  int ready_low;
  int low_left;
  logic ce_seen;
  logic prev_ce;
  logic [7:0] cur_byte;
  logic full_stall_seen;
  logic [7:0] exp_q[$];

  psg_write_sequencer #(
    .FIFO_DEPTH(DEPTH), .GAP_CYCLES(2), .TIMEOUT_CYCLES(200)
  ) dut (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .CE_N(CE_N), .WE_N(WE_N), .D_IN(D_IN), .READY(READY),
    .fifo_count(fifo_count), .busy(busy), .timeout_error(timeout_error),
    .clear_error(clear_error), .o_state(o_state)
  );

  // Clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Chip model: READY drops after CE_N falls and returns after ready_low clocks.
  always @(posedge clock) begin
    #2;
    if (!CE_N && !ce_seen) begin
      ce_seen = 1'b1;
      if (ready_mode != RM_HIGH) begin
        READY    = 1'b0;
        low_left = ready_low;
      end
    end else if (ready_mode == RM_NORMAL && !READY) begin
      if (CE_N || low_left <= 1) READY = 1'b1;
      else low_left--;
    end
    if (CE_N) ce_seen = 1'b0;
  end

  // Scoreboard: each CE_N fall must carry the oldest accepted byte.
  always @(negedge clock) begin
    if (reset) begin
      prev_ce = 1'b1;
    end else begin
      if (prev_ce && !CE_N) begin
        pulses++;
        check_val("we_n_with_ce_n", WE_N, 0);
        if (exp_q.size() == 0) begin
          check_val("unexpected_write", 1, 0);
        end else begin
          cur_byte = exp_q.pop_front();
          check_val("d_in_order", D_IN, cur_byte);
        end
      end
      if (!prev_ce && CE_N) check_val("d_in_hold", D_IN, cur_byte);
      prev_ce = CE_N;
    end
  end

  // Driver: call at a negedge; returns at the negedge after acceptance, in_valid left high.
  task automatic push_byte(input logic [7:0] b);
    int waited;
    in_valid = 1'b1;
    in_data  = b;
    waited   = 0;
    while (!in_ready && waited < 500) begin
      if (!full_stall_seen) begin
        full_stall_seen = 1'b1;
        check_val("stall_at_full", fifo_count, DEPTH);
      end
      @(negedge clock);
      waited++;
    end
    if (!in_ready) begin
      check_val("accept_timeout", 0, 1);
      in_valid = 1'b0;
    end else begin
      exp_q.push_back(b);
      @(negedge clock);
    end
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy && n < 3000) begin
      @(negedge clock);
      n++;
    end
    check_val("idle_reached", busy, 0);
  endtask

  task automatic check_reset_state(input string tag);
    check_val({tag, "_ce_n"}, CE_N, 1);
    check_val({tag, "_we_n"}, WE_N, 1);
    check_val({tag, "_d_in"}, D_IN, 8'hFF);
    check_val({tag, "_count"}, fifo_count, 0);
    check_val({tag, "_in_ready"}, in_ready, 0);
    check_val({tag, "_busy"}, busy, 0);
    check_val({tag, "_tmo"}, timeout_error, 0);
    check_val({tag, "_state"}, o_state, ST_IDLE);
  endtask

  initial begin
    int n;
    int p0;
    logic [7:0] burst[6];
    burst = '{8'h81, 8'h40, 8'h9F, 8'hC3, 8'h1A, 8'hE0};
    vectors = 0; miscompares = 0; pulses = 0;
    ready_mode = RM_NORMAL; ready_low = 32; low_left = 0;
    ce_seen = 1'b0; prev_ce = 1'b1; cur_byte = 8'hFF; full_stall_seen = 1'b1;
    READY = 1'b1; reset = 1'b1; in_valid = 1'b0; in_data = 8'h00; clear_error = 1'b0;

    // Reset state and in_ready release
    @(negedge clock); @(negedge clock);
    check_reset_state("rst");
    reset = 1'b0;
    #1 check_val("in_ready_before_edge", in_ready, 0);
    @(negedge clock);
    check_val("in_ready_after_edge", in_ready, 1);

    // Single byte with 32-clock READY low
    push_byte(8'h80);
    in_valid = 1'b0;
    check_val("single_ce_not_yet", CE_N, 1);
    @(negedge clock);
    check_val("single_ce_low", CE_N, 0);
    check_val("single_d_in", D_IN, 8'h80);
    n = 0;
    while (!READY && n < 100) begin
      @(negedge clock);
      n++;
    end
    check_val("single_ce_held_to_ready", CE_N, 0);
    @(negedge clock);
    check_val("single_ce_release", CE_N, 1);
    check_val("single_state_gap", o_state, ST_GAP);
    @(negedge clock);
    check_val("single_busy_in_gap", busy, 1);
    @(negedge clock);
    check_val("single_busy_fall", busy, 0);
    check_val("single_tmo", timeout_error, 0);
    check_val("single_d_in_kept", D_IN, 8'h80);

    // Burst of 6 with in_valid held; FIFO fills and stalls
    ready_low = 3;
    full_stall_seen = 1'b0;
    p0 = pulses;
    foreach (burst[i]) push_byte(burst[i]);
    in_valid = 1'b0;
    full_stall_seen = 1'b1;
    wait_idle();
    check_val("burst_stall_seen", {31'd0, full_stall_seen}, 1);
    check_val("burst_pulses", pulses - p0, 6);
    check_val("burst_count_zero", fifo_count, 0);
    check_val("burst_queue_drained", exp_q.size(), 0);

    // READY tied high: strobe timeout, next byte still written, clear_error
    ready_mode = RM_HIGH;
    push_byte(8'h90);
    in_valid = 1'b0;
    @(negedge clock);
    n = 0;
    while (!CE_N && n < 400) begin
      n++;
      @(negedge clock);
    end
    check_val("tmo_ce_low_clocks", n, 200);
    check_val("tmo_flag_set", timeout_error, 1);
    wait_idle();
    ready_mode = RM_NORMAL;
    ready_low = 4;
    p0 = pulses;
    push_byte(8'h9F);
    in_valid = 1'b0;
    wait_idle();
    check_val("tmo_next_written", pulses - p0, 1);
    check_val("tmo_sticky", timeout_error, 1);
    clear_error = 1'b1;
    @(negedge clock);
    clear_error = 1'b0;
    check_val("tmo_cleared", timeout_error, 0);

    // READY stuck low: timeout in WAIT_HIGH, set wins over a held clear_error
    ready_mode = RM_STUCK;
    clear_error = 1'b1;
    push_byte(8'hA5);
    in_valid = 1'b0;
    @(negedge clock);
    check_val("stuck_state_strobe", o_state, ST_STROBE);
    n = 0;
    while (!CE_N && n < 400) begin
      n++;
      if (n == 2) check_val("stuck_state_wait", o_state, ST_WAIT);
      @(negedge clock);
    end
    check_val("stuck_ce_low_clocks", n, 201);
    check_val("stuck_tmo_over_clear", timeout_error, 1);
    check_val("stuck_state_gap", o_state, ST_GAP);
    clear_error = 1'b0;
    @(negedge clock);
    check_val("stuck_tmo_sticky", timeout_error, 1);
    @(negedge clock);
    check_val("stuck_state_idle", o_state, ST_IDLE);
    ready_mode = RM_NORMAL;
    clear_error = 1'b1;
    @(negedge clock);
    clear_error = 1'b0;

    // Reset during WAIT_HIGH with 3 bytes queued
    ready_low = 32;
    push_byte(8'h11); push_byte(8'h22); push_byte(8'h33); push_byte(8'h44);
    in_valid = 1'b0;
    check_val("rmid_state_wait", o_state, ST_WAIT);
    check_val("rmid_count", fifo_count, 3);
    #2 reset = 1'b1;
    exp_q.delete();
    #1 check_reset_state("rmid");
    @(negedge clock); @(negedge clock);
    reset = 1'b0;
    p0 = pulses;
    @(negedge clock);
    check_val("rmid_in_ready_back", in_ready, 1);
    repeat (20) @(negedge clock);
    check_val("rmid_no_pulse", pulses - p0, 0);
    check_val("rmid_count_zero", fifo_count, 0);
    check_val("rmid_busy", busy, 0);

    // Push and pop on the same edge at fifo_count == 2
    ready_low = 2;
    push_byte(8'h5A); push_byte(8'hB6); push_byte(8'h3C);
    in_valid = 1'b0;
    n = 0;
    while (o_state != ST_IDLE && n < 200) begin
      @(negedge clock);
      n++;
    end
    check_val("pp_idle_reached", o_state, ST_IDLE);
    check_val("pp_count_before", fifo_count, 2);
    push_byte(8'h7E);
    in_valid = 1'b0;
    check_val("pp_count_after", fifo_count, 2);
    check_val("pp_state_strobe", o_state, ST_STROBE);
    wait_idle();
    check_val("pp_queue_drained", exp_q.size(), 0);

    // Random bytes, gaps and READY lengths
    for (int i = 0; i < 12; i++) begin
      ready_low = $urandom_range(1, 6);
      push_byte(8'($urandom_range(0, 255)));
      in_valid = 1'b0;
      repeat ($urandom_range(0, 3)) @(negedge clock);
    end
    wait_idle();
    check_val("rand_queue_drained", exp_q.size(), 0);
    check_val("rand_tmo_clear", timeout_error, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
